// File: rtl/cpu_mem_arbiter.sv
// Purpose: round-robin arbiter putting CPU fetch and data requesters onto one memory port.
// Latency: req sampled -> mem_req next cycle; mem_ready -> done next cycle; minimum req-to-done is 2 cycles.
// Backpressure: mem_req and mem_* hold until mem_ready; requesters stall (req held) until their done pulse.
//
// Ports:
//   clock, reset          - single clock, synchronous active-high reset
//   if_req/if_addr        - fetch request in; if_rdata/if_done out
//   dm_req/we/addr/wdata  - data request in; dm_rdata/dm_done out
//   mem_req/we/addr/wdata - downstream request out; mem_ready/mem_rdata in
//   err                   - abort pulse, coincident with the aborted done
// Optional: define CPU_MEM_ARB_TIMEOUT_EN to abort a BUSY access after TIMEOUT
// cycles without mem_ready; otherwise BUSY waits forever and err is tied to 0.
module cpu_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, RESP} state_t;

  state_t r_state;
  logic   r_last_d;   // 1 when the most recent grant went to the data requester
  logic   r_err;

  // Data wins when it is the only requester, or on a tie when fetch was granted last.
  logic w_grant_d;
  assign w_grant_d = dm_req & (~if_req | ~r_last_d);

`ifdef CPU_MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] r_cnt;
  assign err = r_err;
`else
  // TIMEOUT only matters when the abort counter is built in.
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT > 1);
  assign err = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_last_d  <= 1'b0;
      r_err     <= 1'b0;
      if_rdata  <= '0;
      if_done   <= 1'b0;
      dm_rdata  <= '0;
      dm_done   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
      r_cnt     <= '0;
`endif
    end else begin
      // Completion and abort flags are single-cycle pulses, raised only on entry to RESP.
      if_done <= 1'b0;
      dm_done <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req || dm_req) begin
            mem_req <= 1'b1;
`ifdef CPU_MEM_ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
            if (w_grant_d) begin
              mem_we    <= dm_we;
              mem_addr  <= dm_addr;
              mem_wdata <= dm_wdata;
              r_last_d  <= 1'b1;
              r_state   <= BUSY_D;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= if_addr;
              mem_wdata <= '0;
              r_last_d  <= 1'b0;
              r_state   <= BUSY_I;
            end
          end
        end
        BUSY_I, BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            r_state <= RESP;
            if (r_state == BUSY_I) begin
              if_done  <= 1'b1;
              if_rdata <= mem_rdata;
            end else begin
              dm_done <= 1'b1;
              // A write completion leaves the last read word in place.
              if (!mem_we) dm_rdata <= mem_rdata;
            end
          end
`ifdef CPU_MEM_ARB_TIMEOUT_EN
          else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            // Counter reaches TIMEOUT at this edge: give up, read data untouched.
            mem_req <= 1'b0;
            r_state <= RESP;
            r_err   <= 1'b1;
            if (r_state == BUSY_I) if_done <= 1'b1;
            else                   dm_done <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        RESP: begin
          // Requests are ignored here; arbitration resumes from IDLE.
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
